// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory port responder with byte-lane RAM access and configurable load latency
module data_mem_responder #(
  parameter int SCALE = 14,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_oe,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_ready,
  output logic        misalign
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d, pend_q, pend_d;
  logic valid_q, valid_d, ready_q, ready_d, mis_q, mis_d;
  logic [31:0] ram [2**SCALE];
  logic [SCALE-1:0] idx;
  logic [1:0] off;
  logic [3:0] mask;
  logic [5:0] lm;
  logic is_st, acc, mis;
  logic [31:0] ld, wsh, bm;
  logic addr_unused;
  assign addr_unused = ^mem_addr[31:2+SCALE];
  always_comb begin
    idx = mem_addr[2+:SCALE];
    off = mem_addr[1:0];
    is_st = |mem_we;
    mask = is_st ? mem_we : mem_oe;
    lm = {2'b00, mask} << off;
    mis = |lm[5:4];
    acc = ready_q && (is_st || |mem_oe);
    bm = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    ld = mis ? '0 : (ram[idx] >> {off, 3'b000}) & bm;
    wsh = mem_wdata << {off, 3'b000};
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    pend_d = pend_q;
    mis_d = acc && mis;
    case (state_q)
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rdata_d = pend_q;
        end
      end
      default: begin
        if (acc && !is_st) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            rdata_d = ld;
          end else begin
            state_d = WAIT;
            cnt_d = 4'(LATENCY - 1);
            pend_d = ld;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    valid_d = state_d == RESP;
    ready_d = state_d != WAIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
      pend_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      pend_q <= pend_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      mis_q <= mis_d;
    end
  end
  // RAM is not cleared by reset; stores only commit on accepted, aligned requests
  always_ff @(posedge clk) begin
    if (!rst && acc && is_st && !mis)
      for (int k = 0; k < 4; k++)
        if (lm[k]) ram[idx][8*k+:8] <= wsh[8*k+:8];
  end
  assign mem_rdata = rdata_q;
  assign mem_valid = valid_q;
  assign mem_ready = ready_q;
  assign misalign = mis_q;
endmodule
